// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
// Contents:
//   word_t / block_t  : 32-bit word and 128-bit block types
//   NR                : number of AES-128 rounds
//   RCON              : round constants for rounds 1..10
//   ks_state_t        : IDLE/EMIT states of the key expander
//   gf_mul, sbox_lookup : GF(2^8) arithmetic behind the combinational S-box
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ks_state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (x^254, which maps 0 to 0) followed by
  // the AES affine transform.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Bus between the key expander and its consumer (load side plus the
// round-key valid/ready stream).
// Modports:
//   master : key expander side (receives load/key/rk_ready, drives keys)
//   slave  : consumer/controller side
interface aes_key_expand_if;
  import aes_pkg::*;

  logic        load;
  block_t      key;
  logic        rk_ready;
  logic        rk_valid;
  block_t      round_key;
  logic [3:0]  round;
  logic        last;
  logic        busy;

  modport master (
    input  load, key, rk_ready,
    output rk_valid, round_key, round, last, busy
  );

  modport slave (
    output load, key, rk_ready,
    input  rk_valid, round_key, round, last, busy
  );
endinterface

// File: rtl/sbox.sv
// Combinational AES S-box, one byte in, one byte out.
// Ports:
//   a : input byte
//   y : substituted byte
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_lookup(a);

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the S-box independently to each byte of a 32-bit word.
// Ports:
//   w : input word
//   s : substituted word
module sub_word
  import aes_pkg::*;
(
  input  word_t w,
  output word_t s
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    sbox u_sbox (
      .a (w[8*b +: 8]),
      .y (s[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule. Captures the cipher key on load and then
// streams round keys 0..10 over a valid/ready handshake, computing each next
// key in the cycle it is accepted.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   kx    : load/key in, round-key stream out (master modport)
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_expand_if.master   kx
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_key_expand supports only NR = 10");
  end

  ks_state_t  state;
  ks_state_t  state_next;
  block_t     rk_q;
  logic [3:0] round_q;

  word_t      w0, w1, w2, w3;
  word_t      sub_w3;
  word_t      t;
  word_t      n0, n1, n2, n3;
  logic [7:0] rcon_byte;
  logic       handshake;
  logic       at_last;

  assign {w0, w1, w2, w3} = rk_q;
  assign at_last   = (round_q == 4'd10);
  assign handshake = (state == EMIT) && kx.rk_ready;

  sub_word u_sub_word (
    .w ({w3[23:0], w3[31:24]}),
    .s (sub_w3)
  );

  // Round constant for the key being produced (round + 1); round 10 has no
  // successor so its lookup is forced to zero to stay inside RCON's range.
  always_comb begin
    rcon_byte = 8'h00;
    if (!at_last) rcon_byte = RCON[int'(round_q) + 1];
  end

  assign t  = sub_w3 ^ {rcon_byte, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // Next state: load always (re)starts emission; the accept of round 10
  // returns to idle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (kx.load) state_next = EMIT;
      EMIT: begin
        if (kx.load)                     state_next = EMIT;
        else if (handshake && at_last)   state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Key/round registers: load wins over a handshake; the round-10 accept
  // leaves both registers holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rk_q    <= '0;
      round_q <= 4'd0;
    end else if (kx.load) begin
      rk_q    <= kx.key;
      round_q <= 4'd0;
    end else if (handshake && !at_last) begin
      rk_q    <= {n0, n1, n2, n3};
      round_q <= round_q + 4'd1;
    end
  end

  assign kx.rk_valid  = (state == EMIT);
  assign kx.round_key = rk_q;
  assign kx.round     = round_q;
  assign kx.last      = (state == EMIT) && at_last;
  assign kx.busy      = (state == EMIT);

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed testbench for aes_key_expand: FIPS-197 key schedules with
// continuous and randomly stalled consumers, load restart mid-schedule,
// asynchronous reset mid-schedule and idle behaviour after completion.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failures = 0;

  logic [127:0] fips_keys [0:10];
  logic [127:0] key_b = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_expand_if kx();

  aes_key_expand #(.NR(10)) dut (
    .clk   (clk),
    .reset (reset),
    .kx    (kx)
  );

  always #5 clk = ~clk;

  // Global guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [127:0] k, input logic rdy);
    kx.load     = ld;
    kx.key      = k;
    kx.rk_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    int e;
    int cycles;
    logic rdy;

    fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    applyStimulus(1'b0, '0, 1'b0);

    // Reset state
    tick();
    tick();
    checkOutput("reset_valid", kx.rk_valid, 0);
    checkOutput("reset_key", kx.round_key, 0);
    checkOutput("reset_round", kx.round, 0);
    checkOutput("reset_last", kx.last, 0);
    checkOutput("reset_busy", kx.busy, 0);
    reset = 1'b0;

    // FIPS-197 App. A key, consumer always ready
    applyStimulus(1'b1, fips_keys[0], 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    for (int r = 0; r <= 10; r++) begin
      checkOutput($sformatf("full_valid_r%0d", r), kx.rk_valid, 1);
      checkOutput($sformatf("full_round_r%0d", r), kx.round, r);
      checkOutput($sformatf("full_key_r%0d", r), kx.round_key, fips_keys[r]);
      checkOutput($sformatf("full_last_r%0d", r), kx.last, (r == 10) ? 1 : 0);
      checkOutput($sformatf("full_busy_r%0d", r), kx.busy, 1);
      tick();
    end
    checkOutput("full_done_busy", kx.busy, 0);
    checkOutput("full_done_valid", kx.rk_valid, 0);
    checkOutput("full_done_round", kx.round, 10);

    // Same key, consumer ready about half the time
    applyStimulus(1'b1, fips_keys[0], 1'b0);
    tick();
    kx.load = 1'b0;
    e = 0;
    cycles = 0;
    while (e <= 10 && cycles < 400) begin
      checkOutput($sformatf("stall_valid_e%0d", e), kx.rk_valid, 1);
      checkOutput($sformatf("stall_round_e%0d", e), kx.round, e);
      checkOutput($sformatf("stall_key_e%0d", e), kx.round_key, fips_keys[e]);
      rdy = 1'($urandom_range(0, 1));
      kx.rk_ready = rdy;
      tick();
      if (rdy) e++;
      cycles++;
    end
    checkOutput("stall_completed", e, 11);
    checkOutput("stall_done_valid", kx.rk_valid, 0);

    // Load of a new key at round 5 with a simultaneous handshake
    applyStimulus(1'b1, fips_keys[0], 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("restart_pre_round", kx.round, 5);
    applyStimulus(1'b1, key_b, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("restart_round0", kx.round, 0);
    checkOutput("restart_key0", kx.round_key, key_b);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("restart_round10", kx.round, 10);
    checkOutput("restart_key10", kx.round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    checkOutput("restart_last", kx.last, 1);
    tick();
    checkOutput("restart_done_busy", kx.busy, 0);

    // Asynchronous reset at round 4
    applyStimulus(1'b1, fips_keys[0], 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("areset_pre_round", kx.round, 4);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("areset_valid", kx.rk_valid, 0);
    checkOutput("areset_key", kx.round_key, 0);
    checkOutput("areset_round", kx.round, 0);
    checkOutput("areset_busy", kx.busy, 0);
    checkOutput("areset_last", kx.last, 0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("areset_after_valid_%0d", i), kx.rk_valid, 0);
    end

    // All-zero key, then rk_ready held in IDLE
    applyStimulus(1'b1, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("zero_key0", kx.round_key, 0);
    tick();
    checkOutput("zero_key1", kx.round_key, 128'h62636363626363636263636362636363);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("zero_round10", kx.round, 10);
    checkOutput("zero_key10", kx.round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    checkOutput("zero_last", kx.last, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("zero_idle_valid_%0d", i), kx.rk_valid, 0);
      checkOutput($sformatf("zero_idle_key_%0d", i), kx.round_key,
                  128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES-128 key schedule (FIPS-197 §5.2, Nk = 4, Nr = 10) that sits directly upstream of `aes_core`. It captures the 128-bit cipher key from the SPI-loaded register when `load` is asserted. It then delivers round keys 0..10 one at a time over a valid/ready handshake, so the core's add-round-key stage consumes one key per round instead of holding all 1408 bits of expanded key.

## Interface
Parameters:
- `NR`, default 10: number of rounds. Only 10 is legal; elaboration fails on any other value.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle start; samples `key` this edge.
- `key`  in  128  cipher key; w[0] = [127:96] … w[3] = [31:0].
- `rk_ready`  in  1  consumer accepts the current round key.
- `rk_valid`  out  1  `round_key`/`round` hold a valid key.
- `round_key`  out  128  current round key, same word packing as `key`.
- `round`  out  4  index of `round_key`, 0..10.
- `last`  out  1  `rk_valid && round == 10`.
- `busy`  out  1  high from `load` until the round-10 key is accepted.

## Operation
- State machine: IDLE, EMIT.
- IDLE:
  - `rk_valid = 0`.
  - `load` → `round_key <= key`, `round <= 0`, go to EMIT.
- EMIT:
  - `rk_valid = 1`.
  - On a handshake (`rk_valid && rk_ready`) with `round < 10`: `round_key <= next_key(round_key, round+1)`, `round <= round + 1`, stay in EMIT.
  - On a handshake with `round == 10`: go to IDLE; `round_key` and `round` hold their values.
  - No handshake: all outputs hold, and `round_key` is stable while `rk_valid && !rk_ready`.
- `next_key` for round i, with words w0..w3 of the current key:
  - t = SubWord(RotWord(w3)) ^ {RCON[i], 24'h0}
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2
- `RCON[1..10]` = 01,02,04,08,10,20,40,80,1b,36.
- Boundary conditions:
  - `load` has priority over a handshake in the same cycle, in any state, and restarts at round 0 with the new key.
  - `load` in EMIT mid-schedule aborts the current schedule with no extra output.
  - `rk_ready` in IDLE is ignored.
  - `round` never exceeds 10 and never wraps.
- Reset (asynchronous, any time):
  - state = IDLE, `round_key = 0`, `round = 0`, `rk_valid = 0`, `last = 0`, `busy = 0`.
  - A reset mid-schedule discards the schedule; a new `load` is required.

## Timing
- `load` at edge k → `rk_valid = 1`, `round = 0` after edge k; `round_key` equals the sampled `key`.
- Handshake at edge m → the next key is visible after edge m, so one round key per cycle when `rk_ready` is held high.
- Full schedule with `rk_ready` tied high: 11 cycles from the first valid to the last accept. `busy` falls after the accepting edge of round 10.
- All outputs are registered or decoded from registers only; no combinational path from `rk_ready` or `load` to any output.
- The critical path is one `sub_word` lookup plus a 4-deep XOR chain and must close at the core clock.

## Structure
- Shared package `aes_pkg` holds:
  - `typedef logic [31:0] word_t`
  - `typedef logic [127:0] block_t`
  - `localparam NR = 10`
  - `localparam logic [7:0] RCON [1:10]`
  - The IDLE/EMIT state enum.
- One sub-module, `sub_word`: 32-bit in and out, four instances of the existing combinational `sbox` (needs `sbox.txt`). Do not use `sbox_sync`; the single-cycle-per-key timing depends on a combinational lookup.
- Top level contains only the state register, the key/round registers and the `next_key` XOR network.

## Test plan
- FIPS-197 App. A key `2b7e151628aed2a6abf7158809cf4f3c`, `load`, `rk_ready` = 1 →
  - round 0 = key
  - round 1 = `a0fafe1788542cb123a339392a6c7605`
  - round 2 = `f2c295f27a96b9435935807a7359f67f`
  - round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`, with `last` = 1 exactly on that cycle
  - `busy` low the cycle after.
- Same key, `rk_ready` toggling randomly (~50%) → identical 11-key sequence; `round_key` and `round` stable across every stalled cycle; no key skipped or repeated.
- `load` with key `000102030405060708090a0b0c0d0e0f` while at round 5 of a previous schedule, `rk_ready` = 1 same cycle → next output is round 0 = new key; round 10 = `13111d7fe3944a17f307a78b4d2b30c5`.
- `reset` pulsed mid-schedule (round 4), asynchronous to clk → all outputs 0 immediately; `rk_ready` afterwards gives no `rk_valid` until a new `load`.
- Key all-zero → round 1 = `62636363626363636263636362636363`, round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`; `rk_ready` held in IDLE after completion → nothing emitted.
